// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS32 control FSM: IF/ID/EX/MEM/WB sequencing, decode and retire counting.
// Optional ILLEGAL_TRAP_EN: unlisted encodings trap in ID instead of executing as NOP.
module mcycle_ctrl #(
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ins,
  input  logic               memReady,
  output logic [2:0]         state,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               regDst,
  output logic               aluSrc,
  output logic               extOp,
  output logic               memToReg,
  output logic               pcWr,
  output logic               irWr,
  output logic               memRd,
  output logic               memWr,
  output logic               regWr,
  output logic               branch,
  output logic               jump,
  output logic               retire,
  output logic [CNT_W-1:0]   instCnt,
  output logic               excp
);

  typedef enum logic [2:0] {
    sIf   = 3'd0,
    sId   = 3'd1,
    sEx   = 3'd2,
    sMem  = 3'd3,
    sWb   = 3'd4,
    sTrap = 3'd5
  } stateT;

  typedef enum logic [2:0] {
    clsAlu,
    clsBranch,
    clsJump,
    clsLink,
    clsLoad,
    clsStore,
    clsIllegal
  } clsT;

  stateT      curState;
  stateT      nextState;
  clsT        cls;
  logic [4:0] decOp;
  logic       decRegDst;
  logic       decAluSrc;
  logic       decExtOp;
  logic       decMemToReg;
  logic       retireNext;
  logic       unusedIns;

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode    = ins[31:26];
  assign funct     = ins[5:0];
  assign unusedIns = &{1'b0, ins[25:21], ins[16], ins[15:6]};
  assign state     = curState;

  // Instruction decode; ins is stable from ID to the end of the instruction
  always_comb begin
    cls         = clsIllegal;
    decOp       = 5'd0;
    decRegDst   = 1'b0;
    decAluSrc   = 1'b0;
    decExtOp    = 1'b0;
    decMemToReg = 1'b0;
    case (opcode)
      6'h00: begin
        cls       = clsAlu;
        decRegDst = 1'b1;
        case (funct)
          6'h00:   decOp = 5'd7;
          6'h02:   decOp = 5'd8;
          6'h03:   decOp = 5'd13;
          6'h04:   decOp = 5'd12;
          6'h06:   decOp = 5'd15;
          6'h07:   decOp = 5'd14;
          6'h08:   begin decOp = 5'd11; cls = clsJump; end
          6'h09:   begin decOp = 5'd10; cls = clsLink; end
          6'h20,
          6'h21:   decOp = 5'd0;
          6'h22,
          6'h23:   decOp = 5'd1;
          6'h24:   decOp = 5'd3;
          6'h25:   decOp = 5'd5;
          6'h26:   decOp = 5'd6;
          6'h27:   decOp = 5'd4;
          6'h2A:   decOp = 5'd2;
          6'h2B:   decOp = 5'd9;
          default: begin cls = clsIllegal; decRegDst = 1'b0; end
        endcase
      end
      6'h01:   if (ins[20:17] == 4'd0) cls = clsBranch;
      6'h02:   cls = clsJump;
      6'h03:   begin cls = clsLink; decOp = 5'd10; end
      6'h04,
      6'h05:   begin cls = clsBranch; decOp = 5'd1; end
      6'h06,
      6'h07:   cls = clsBranch;
      6'h09:   begin cls = clsAlu; decAluSrc = 1'b1; decExtOp = 1'b1; end
      6'h0A:   begin cls = clsAlu; decOp = 5'd2; decAluSrc = 1'b1; decExtOp = 1'b1; end
      6'h0B:   begin cls = clsAlu; decOp = 5'd9; decAluSrc = 1'b1; end
      6'h0C:   begin cls = clsAlu; decOp = 5'd3; decAluSrc = 1'b1; end
      6'h0D:   begin cls = clsAlu; decOp = 5'd5; decAluSrc = 1'b1; end
      6'h0E:   begin cls = clsAlu; decOp = 5'd6; decAluSrc = 1'b1; end
      6'h0F:   begin cls = clsAlu; decOp = 5'd16; decAluSrc = 1'b1; end
      6'h20,
      6'h23,
      6'h24: begin
        cls         = clsLoad;
        decAluSrc   = 1'b1;
        decExtOp    = 1'b1;
        decMemToReg = 1'b1;
      end
      6'h28,
      6'h2B:   begin cls = clsStore; decAluSrc = 1'b1; decExtOp = 1'b1; end
      default: cls = clsIllegal;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) curState <= sIf;
    else     curState <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = curState;
    case (curState)
      sIf: if (memReady) nextState = sId;
      sId: begin
        nextState = sEx;
`ifdef ILLEGAL_TRAP_EN
        if (cls == clsIllegal) nextState = sTrap;
`endif
      end
      sEx: begin
        case (cls)
          clsAlu:            nextState = sWb;
          clsLoad, clsStore: nextState = sMem;
          default:           nextState = sIf;
        endcase
      end
      sMem:    if (memReady) nextState = (cls == clsLoad) ? sWb : sIf;
      sWb:     nextState = sIf;
      sTrap:   nextState = sTrap;
      default: nextState = sIf;
    endcase
  end

  // Outputs: strobes are forced low while rst is held, aborting any access
  always_comb begin
    pcWr     = 1'b0;
    irWr     = 1'b0;
    memRd    = 1'b0;
    memWr    = 1'b0;
    regWr    = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    aluOp    = '0;
    regDst   = 1'b0;
    aluSrc   = 1'b0;
    extOp    = 1'b0;
    memToReg = 1'b0;
    if (!rst) begin
      case (curState)
        sIf: begin
          memRd = 1'b1;
          pcWr  = memReady;
          irWr  = memReady;
        end
        sEx: begin
          branch = (cls == clsBranch);
          jump   = (cls == clsJump) || (cls == clsLink);
          regWr  = (cls == clsLink);
        end
        sMem: begin
          memRd = (cls == clsLoad);
          memWr = (cls == clsStore);
        end
        sWb:     regWr = 1'b1;
        default: ;
      endcase
      if (curState inside {sId, sEx, sMem, sWb}) begin
        aluOp    = ALUOP_W'(decOp);
        regDst   = decRegDst;
        aluSrc   = decAluSrc;
        extOp    = decExtOp;
        memToReg = decMemToReg;
      end
    end
  end

  assign retireNext = (nextState == sIf) && (curState inside {sEx, sMem, sWb});

  // Retire pulse and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire  <= 1'b0;
      instCnt <= '0;
    end else begin
      retire <= retireNext;
      if (retireNext) instCnt <= instCnt + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign excp = (curState == sTrap);
`else
  assign excp = 1'b0;
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: per-instruction vector table plus reset, wrap and trap sequences.
module tb_mcycle_ctrl;
  localparam int unsigned AW = 6;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic [31:0]   ins;
  logic          memReady;
  logic [2:0]    state;
  logic [AW-1:0] aluOp;
  logic          regDst, aluSrc, extOp, memToReg;
  logic          pcWr, irWr, memRd, memWr, regWr, branch, jump;
  logic          retire;
  logic [CW-1:0] instCnt;
  logic          excp;

  int nChecks = 0;
  int nFails  = 0;
  int expCnt  = 0;

  mcycle_ctrl #(.ALUOP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ins(ins), .memReady(memReady), .state(state),
    .aluOp(aluOp), .regDst(regDst), .aluSrc(aluSrc), .extOp(extOp), .memToReg(memToReg),
    .pcWr(pcWr), .irWr(irWr), .memRd(memRd), .memWr(memWr), .regWr(regWr),
    .branch(branch), .jump(jump), .retire(retire), .instCnt(instCnt), .excp(excp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] ins;
    logic [5:0]  op;
    logic        rd, src, ext, m2r;
    int          ifWait, memWait, cycles;
    int          br, jmp, rw, mw, mr;
  } vecT;

  vecT vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] packStb(input int pw, input int iw, input int mr, input int mw,
                                          input int rw, input int br, input int jmp, input int ex);
    return {8'(pw), 8'(iw), 8'(mr), 8'(mw), 8'(rw), 8'(br), 8'(jmp), 8'(ex)};
  endfunction

  // Runs one instruction from the start of an IF cycle back to the next IF
  task automatic runInstr(input vecT v);
    int   cyc = 0, ifCyc = 1, memCyc = 0;
    int   pw = 0, iw = 0, mr = 0, mw = 0, rw = 0, br = 0, jmp = 0, ex = 0;
    logic [9:0] idSel = '0;
    logic [9:0] curSel;
    bit   holdErr = 0, sawOther = 0, done = 0;
    ins      = v.ins;
    memReady = (v.ifWait == 0);
    while (!done && cyc < 40) begin
      @(negedge clk);
      pw += int'(pcWr);  iw += int'(irWr);  mr += int'(memRd); mw += int'(memWr);
      rw += int'(regWr); br += int'(branch); jmp += int'(jump); ex += int'(excp);
      curSel = {aluOp, regDst, aluSrc, extOp, memToReg};
      if (state == 3'd1) idSel = curSel;
      else if (state != 3'd0 && curSel !== idSel) holdErr = 1;
      @(posedge clk);
      #1;
      cyc++;
      if (state != 3'd0) sawOther = 1;
      if (state == 3'd0) begin
        if (sawOther) done = 1;
        else begin
          memReady = (ifCyc >= v.ifWait);
          ifCyc++;
        end
      end else if (state == 3'd3) begin
        memReady = (memCyc >= v.memWait);
        memCyc++;
      end else begin
        memReady = 1'b1;
      end
    end
    expCnt++;
    check($sformatf("%08h done", v.ins), 64'(done), 64'd1);
    check($sformatf("%08h cycles", v.ins), 64'(cyc), 64'(v.cycles));
    check($sformatf("%08h decode", v.ins), 64'(idSel), 64'({v.op, v.rd, v.src, v.ext, v.m2r}));
    check($sformatf("%08h strobes", v.ins), packStb(pw, iw, mr, mw, rw, br, jmp, ex),
          packStb(1, 1, v.mr, v.mw, v.rw, v.br, v.jmp, 0));
    check($sformatf("%08h selhold", v.ins), 64'(holdErr), 64'd0);
    check($sformatf("%08h retire", v.ins), 64'(retire), 64'd1);
    check($sformatf("%08h instCnt", v.ins), 64'(instCnt), 64'(expCnt % 16));
  endtask

  vecT jv;

  initial begin
    //                ins           op     rd    src   ext   m2r  ifW memW cyc br jmp rw mw mr
    vecs.push_back('{32'h00430821, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430821, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 6, 0, 0, 1, 0, 3});
    vecs.push_back('{32'h00430820, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430822, 6'd1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430823, 6'd1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h0043082A, 6'd2,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430824, 6'd3,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430827, 6'd4,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430825, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430826, 6'd6,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00021080, 6'd7,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00021082, 6'd8,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h0043082B, 6'd9,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430804, 6'd12, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00021083, 6'd13, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430807, 6'd14, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h00430806, 6'd15, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h03E00008, 6'd11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 1, 0, 0, 1});
    vecs.push_back('{32'h0040F809, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 1, 1, 0, 1});
    vecs.push_back('{32'h08000010, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 1, 0, 0, 1});
    vecs.push_back('{32'h0C000010, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 1, 1, 0, 1});
    vecs.push_back('{32'h10220003, 6'd1,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0, 0, 1});
    vecs.push_back('{32'h14220003, 6'd1,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0, 0, 1});
    vecs.push_back('{32'h18400003, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0, 0, 1});
    vecs.push_back('{32'h1C400003, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0, 0, 1});
    vecs.push_back('{32'h04400003, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0, 0, 1});
    vecs.push_back('{32'h04410003, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0, 0, 1});
    vecs.push_back('{32'h24220005, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h28220005, 6'd2,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h2C220005, 6'd9,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h30220005, 6'd3,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h34220005, 6'd5,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h38220005, 6'd6,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h3C020005, 6'd16, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1});
    vecs.push_back('{32'h80220000, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 5, 0, 0, 1, 0, 2});
    vecs.push_back('{32'h90220000, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 5, 0, 0, 1, 0, 2});
    vecs.push_back('{32'h8C220004, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 5, 0, 0, 1, 0, 2});
    vecs.push_back('{32'h8C220004, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1, 0, 3, 8, 0, 0, 1, 0, 5});
    vecs.push_back('{32'hA0220000, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 4, 0, 0, 0, 1, 1});
    vecs.push_back('{32'hAC220000, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 4, 0, 0, 0, 1, 1});
    vecs.push_back('{32'hAC220000, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 2, 6, 0, 0, 0, 3, 1});
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back('{32'hFC000000, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 0, 0, 1});
    vecs.push_back('{32'h00000001, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 0, 0, 1});
`endif
    jv = '{32'h08000010, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 1, 0, 0, 1};

    // Reset values while rst is held (state is IF, but no fetch strobe)
    rst      = 1'b1;
    memReady = 1'b1;
    ins      = 32'h00430821;
    #12;
    check("rst state", 64'(state), 64'd0);
    check("rst strobes", 64'({pcWr, irWr, memRd, memWr, regWr, branch, jump}), 64'd0);
    check("rst instCnt", 64'(instCnt), 64'd0);
    check("rst retire excp", 64'({retire, excp}), 64'd0);
    check("rst selects", 64'({aluOp, regDst, aluSrc, extOp, memToReg}), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    memReady = 1'b0;
    @(negedge clk);
    check("first fetch", 64'({state, memRd, pcWr, irWr}), 64'({3'd0, 1'b1, 1'b0, 1'b0}));
    @(posedge clk);
    #1;

    foreach (vecs[i]) runInstr(vecs[i]);

    // Reset asserted in the middle of a stalled SW access
    ins      = 32'hAC220000;
    memReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    memReady = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("sw in mem", 64'({state, memWr}), 64'({3'd3, 1'b1}));
    #2 rst = 1'b1;
    #1;
    check("midrst state", 64'(state), 64'd0);
    check("midrst strobes", 64'({memWr, memRd, regWr}), 64'd0);
    check("midrst instCnt", 64'(instCnt), 64'd0);
    expCnt = 0;
    @(posedge clk);
    #1;
    check("midrst hold", 64'({state, memWr, regWr}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("refetch", 64'({state, memRd, memWr}), 64'({3'd0, 1'b1, 1'b0}));
    @(posedge clk);
    #1;

    // Counter wrap with a 4-bit counter, then confirm retire is a single pulse
    for (int k = 0; k < 15; k++) runInstr(jv);
    check("cnt 15", 64'(instCnt), 64'd15);
    runInstr(jv);
    check("cnt wrap", 64'(instCnt), 64'd0);
    memReady = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("retire pulse", 64'({retire, state, memRd, pcWr}), 64'({1'b0, 3'd0, 1'b1, 1'b0}));
    @(posedge clk); #1;

`ifdef ILLEGAL_TRAP_EN
    // Illegal opcode locks in TRAP until reset
    ins      = 32'hFC000000;
    memReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("trap state", 64'({state, excp}), 64'({3'd5, 1'b1}));
      check("trap strobes", 64'({pcWr, irWr, memRd, memWr, regWr, branch, jump, retire}), 64'd0);
      check("trap instCnt", 64'(instCnt), 64'(expCnt % 16));
    end
    rst = 1'b1;
    #1;
    check("trap exit", 64'({state, excp}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
`else
    check("excp tied", 64'(excp), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
